regfile_mp: RTL and testbench

- Parametrised multi-port register file; next generation of the team's 8x8 two-read/one-write register file.
- Adds the following:
  - configurable width, depth and read-port count
  - two write ports with fixed priority
  - synchronous reset clear
  - optional hardwired-zero entry 0
  - per-entry busy scoreboard for the datapath issue logic
- Sits between decode/issue and the ALU/bus-interface writeback in the APB/I2C controller datapath.

---
 rtl/regfile_mp.sv | 99 +++++++++
 tb/tb_regfile_mp.sv | 247 ++++++++++++++++++++++++
 2 files changed

// File: rtl/regfile_mp.sv
`default_nettype none
// ============================================================================
// Module      : regfile_mp
// Description : Parametrised multi-port register file with two prioritised
//               write ports, synchronous clear, optional hardwired-zero entry 0
//               and a per-entry busy scoreboard. Define REGFILE_MP_BYPASS_EN
//               for same-cycle write-to-read forwarding.
// Revision    : 1.0 - initial release
// ============================================================================
module regfile_mp #(
    parameter int DATA_W   = 8,
    parameter int ADDR_W   = 3,
    parameter int NUM_RD   = 2,
    parameter int ZERO_REG = 0
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     wr0_en,
    input  logic [ADDR_W-1:0]        wr0_addr,
    input  logic [DATA_W-1:0]        wr0_data,
    input  logic                     wr1_en,
    input  logic [ADDR_W-1:0]        wr1_addr,
    input  logic [DATA_W-1:0]        wr1_data,
    input  logic [NUM_RD*ADDR_W-1:0] rd_addr,
    output logic [NUM_RD*DATA_W-1:0] rd_data,
    output logic [NUM_RD-1:0]        rd_busy,
    input  logic                     bsy_set_en,
    input  logic [ADDR_W-1:0]        bsy_set_addr,
    output logic [(2**ADDR_W)-1:0]   busy_vec
);

    localparam int   c_DEPTH   = 2**ADDR_W;
    localparam logic c_ZERO_EN = (ZERO_REG != 0);

    logic [DATA_W-1:0]  r_mem [c_DEPTH];
    logic [c_DEPTH-1:0] r_busy;

    logic               w_wr0_ok;
    logic               w_wr1_ok;
    logic               w_set_ok;
    logic [c_DEPTH-1:0] w_busy_nxt;

    // Set is applied after the write clears so a newly issued producer wins.
    always_comb begin
        w_wr0_ok   = wr0_en     && !(c_ZERO_EN && (wr0_addr == '0));
        w_wr1_ok   = wr1_en     && !(c_ZERO_EN && (wr1_addr == '0));
        w_set_ok   = bsy_set_en && !(c_ZERO_EN && (bsy_set_addr == '0));
        w_busy_nxt = r_busy;
        if (w_wr0_ok) w_busy_nxt[wr0_addr]     = 1'b0;
        if (w_wr1_ok) w_busy_nxt[wr1_addr]     = 1'b0;
        if (w_set_ok) w_busy_nxt[bsy_set_addr] = 1'b1;
    end

    // wr1 is written last so it overrides wr0 on an address collision.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < c_DEPTH; i++) r_mem[i] <= '0;
            r_busy <= '0;
        end else begin
            if (w_wr0_ok) r_mem[wr0_addr] <= wr0_data;
            if (w_wr1_ok) r_mem[wr1_addr] <= wr1_data;
            r_busy <= w_busy_nxt;
        end
    end

    assign busy_vec = r_busy;

    for (genvar k = 0; k < NUM_RD; k++) begin : g_rd
        logic [ADDR_W-1:0] w_addr;
        logic [DATA_W-1:0] w_data;
        logic              w_bsy;

        assign w_addr = rd_addr[k*ADDR_W +: ADDR_W];

        always_comb begin
            w_data = r_mem[w_addr];
            w_bsy  = r_busy[w_addr];
`ifdef REGFILE_MP_BYPASS_EN
            if (w_wr0_ok && (wr0_addr == w_addr)) begin
                w_data = wr0_data;
                w_bsy  = w_busy_nxt[w_addr];
            end
            if (w_wr1_ok && (wr1_addr == w_addr)) begin
                w_data = wr1_data;
                w_bsy  = w_busy_nxt[w_addr];
            end
`endif
            if (c_ZERO_EN && (w_addr == '0)) begin
                w_data = '0;
                w_bsy  = 1'b0;
            end
        end

        assign rd_data[k*DATA_W +: DATA_W] = w_data;
        assign rd_busy[k]                  = w_bsy;
    end

endmodule
`default_nettype wire

// File: tb/tb_regfile_mp.sv
`default_nettype none
// ============================================================================
// Module      : tb_regfile_mp
// Description : Self-checking bench for regfile_mp: default, ZERO_REG=1 and
//               wide four-port instances. Expectations follow REGFILE_MP_BYPASS_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_regfile_mp;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    // Shared stimulus for the default (u_a) and zero-register (u_z) instances.
    logic        rst, wr0_en, wr1_en, bsy_set_en;
    logic [2:0]  wr0_addr, wr1_addr, bsy_set_addr;
    logic [7:0]  wr0_data, wr1_data;
    logic [5:0]  rd_addr;
    logic [15:0] a_rd_data, z_rd_data;
    logic [1:0]  a_rd_busy, z_rd_busy;
    logic [7:0]  a_busy_vec, z_busy_vec;

    // Wide instance stimulus.
    logic        q_rst, q_wr0_en, q_wr1_en, q_bsy_set_en;
    logic [2:0]  q_wr0_addr, q_wr1_addr, q_bsy_set_addr;
    logic [15:0] q_wr0_data, q_wr1_data;
    logic [11:0] q_rd_addr;
    logic [63:0] q_rd_data;
    logic [3:0]  q_rd_busy;
    logic [7:0]  q_busy_vec;

    regfile_mp #(.DATA_W(8), .ADDR_W(3), .NUM_RD(2), .ZERO_REG(0)) u_a (
        .clk(clk), .rst(rst),
        .wr0_en(wr0_en), .wr0_addr(wr0_addr), .wr0_data(wr0_data),
        .wr1_en(wr1_en), .wr1_addr(wr1_addr), .wr1_data(wr1_data),
        .rd_addr(rd_addr), .rd_data(a_rd_data), .rd_busy(a_rd_busy),
        .bsy_set_en(bsy_set_en), .bsy_set_addr(bsy_set_addr), .busy_vec(a_busy_vec)
    );

    regfile_mp #(.DATA_W(8), .ADDR_W(3), .NUM_RD(2), .ZERO_REG(1)) u_z (
        .clk(clk), .rst(rst),
        .wr0_en(wr0_en), .wr0_addr(wr0_addr), .wr0_data(wr0_data),
        .wr1_en(wr1_en), .wr1_addr(wr1_addr), .wr1_data(wr1_data),
        .rd_addr(rd_addr), .rd_data(z_rd_data), .rd_busy(z_rd_busy),
        .bsy_set_en(bsy_set_en), .bsy_set_addr(bsy_set_addr), .busy_vec(z_busy_vec)
    );

    regfile_mp #(.DATA_W(16), .ADDR_W(3), .NUM_RD(4), .ZERO_REG(0)) u_w (
        .clk(clk), .rst(q_rst),
        .wr0_en(q_wr0_en), .wr0_addr(q_wr0_addr), .wr0_data(q_wr0_data),
        .wr1_en(q_wr1_en), .wr1_addr(q_wr1_addr), .wr1_data(q_wr1_data),
        .rd_addr(q_rd_addr), .rd_data(q_rd_data), .rd_busy(q_rd_busy),
        .bsy_set_en(q_bsy_set_en), .bsy_set_addr(q_bsy_set_addr), .busy_vec(q_busy_vec)
    );

    typedef struct {
        logic        rst;
        logic        w0e;
        logic [2:0]  w0a;
        logic [7:0]  w0d;
        logic        w1e;
        logic [2:0]  w1a;
        logic [7:0]  w1d;
        logic        se;
        logic [2:0]  sa;
        logic [5:0]  ra;
        logic [15:0] a_rd;
        logic [1:0]  a_rb;
        logic [7:0]  a_bv;
        logic [15:0] z_rd;
        logic [1:0]  z_rb;
        logic [7:0]  z_bv;
    } vec_t;

    typedef struct {
        string       tag;
        int          sel;
        logic [63:0] val;
    } sb_t;

    vec_t vecs [12];
    sb_t  sb [$];
    int   n_cmp = 0;
    int   n_bad = 0;

    function automatic logic [63:0] actual(input int sel);
        case (sel)
            0:       return {48'd0, a_rd_data};
            1:       return {62'd0, a_rd_busy};
            2:       return {56'd0, a_busy_vec};
            3:       return {48'd0, z_rd_data};
            4:       return {62'd0, z_rd_busy};
            5:       return {56'd0, z_busy_vec};
            6:       return q_rd_data;
            7:       return {60'd0, q_rd_busy};
            default: return {56'd0, q_busy_vec};
        endcase
    endfunction

    task automatic push(input string tag, input int sel, input logic [63:0] val);
        sb_t e;
        e.tag = tag;
        e.sel = sel;
        e.val = val;
        sb.push_back(e);
    endtask

    task automatic drain();
        sb_t         e;
        logic [63:0] act;
        while (sb.size() > 0) begin
            e   = sb.pop_front();
            act = actual(e.sel);
            n_cmp++;
            if (act !== e.val) begin
                n_bad++;
                $display("FAIL %s: got %h, need %h", e.tag, act, e.val);
            end
        end
    endtask

    task automatic apply(input vec_t v, input int idx);
        @(negedge clk);
        rst = v.rst;
        wr0_en = v.w0e; wr0_addr = v.w0a; wr0_data = v.w0d;
        wr1_en = v.w1e; wr1_addr = v.w1a; wr1_data = v.w1d;
        bsy_set_en = v.se; bsy_set_addr = v.sa;
        @(posedge clk);
        #1;
        rst = 1'b0; wr0_en = 1'b0; wr1_en = 1'b0; bsy_set_en = 1'b0;
        rd_addr = v.ra;
        push($sformatf("v%0d a_rd_data", idx), 0, {48'd0, v.a_rd});
        push($sformatf("v%0d a_rd_busy", idx), 1, {62'd0, v.a_rb});
        push($sformatf("v%0d a_busy_vec", idx), 2, {56'd0, v.a_bv});
        push($sformatf("v%0d z_rd_data", idx), 3, {48'd0, v.z_rd});
        push($sformatf("v%0d z_rd_busy", idx), 4, {62'd0, v.z_rb});
        push($sformatf("v%0d z_busy_vec", idx), 5, {56'd0, v.z_bv});
        #1;
        drain();
    endtask

    initial begin
        rst = 1'b0; wr0_en = 1'b0; wr1_en = 1'b0; bsy_set_en = 1'b0;
        wr0_addr = '0; wr1_addr = '0; bsy_set_addr = '0;
        wr0_data = '0; wr1_data = '0; rd_addr = '0;
        q_rst = 1'b0; q_wr0_en = 1'b0; q_wr1_en = 1'b0; q_bsy_set_en = 1'b0;
        q_wr0_addr = '0; q_wr1_addr = '0; q_bsy_set_addr = '0;
        q_wr0_data = '0; q_wr1_data = '0; q_rd_addr = '0;

        // rd_addr is {port1, port0}; rd data/busy read as {port1, port0}.
        vecs[0]  = '{1'b1, 1'b1, 3'd3, 8'hA5, 1'b0, 3'd0, 8'h00, 1'b0, 3'd0, 6'o03,
                     16'h0000, 2'b00, 8'h00, 16'h0000, 2'b00, 8'h00};
        vecs[1]  = '{1'b0, 1'b1, 3'd3, 8'hA5, 1'b0, 3'd0, 8'h00, 1'b0, 3'd0, 6'o13,
                     16'h00A5, 2'b00, 8'h00, 16'h00A5, 2'b00, 8'h00};
        vecs[2]  = '{1'b1, 1'b0, 3'd0, 8'h00, 1'b1, 3'd1, 8'h77, 1'b0, 3'd0, 6'o13,
                     16'h0000, 2'b00, 8'h00, 16'h0000, 2'b00, 8'h00};
        vecs[3]  = '{1'b0, 1'b1, 3'd5, 8'h11, 1'b1, 3'd5, 8'h22, 1'b0, 3'd0, 6'o55,
                     16'h2222, 2'b00, 8'h00, 16'h2222, 2'b00, 8'h00};
        vecs[4]  = '{1'b0, 1'b1, 3'd5, 8'h33, 1'b1, 3'd6, 8'h44, 1'b0, 3'd0, 6'o65,
                     16'h4433, 2'b00, 8'h00, 16'h4433, 2'b00, 8'h00};
        vecs[5]  = '{1'b0, 1'b0, 3'd0, 8'h00, 1'b0, 3'd0, 8'h00, 1'b1, 3'd2, 6'o62,
                     16'h4400, 2'b01, 8'h04, 16'h4400, 2'b01, 8'h04};
        vecs[6]  = '{1'b0, 1'b1, 3'd2, 8'h5A, 1'b0, 3'd0, 8'h00, 1'b0, 3'd0, 6'o52,
                     16'h335A, 2'b00, 8'h00, 16'h335A, 2'b00, 8'h00};
        vecs[7]  = '{1'b0, 1'b0, 3'd0, 8'h00, 1'b1, 3'd2, 8'h6B, 1'b1, 3'd2, 6'o22,
                     16'h6B6B, 2'b11, 8'h04, 16'h6B6B, 2'b11, 8'h04};
        vecs[8]  = '{1'b0, 1'b0, 3'd0, 8'h00, 1'b0, 3'd0, 8'h00, 1'b1, 3'd2, 6'o72,
                     16'h006B, 2'b01, 8'h04, 16'h006B, 2'b01, 8'h04};
        vecs[9]  = '{1'b0, 1'b1, 3'd0, 8'hFF, 1'b0, 3'd0, 8'h00, 1'b1, 3'd0, 6'o20,
                     16'h6BFF, 2'b11, 8'h05, 16'h6B00, 2'b10, 8'h04};
        vecs[10] = '{1'b0, 1'b1, 3'd0, 8'hEE, 1'b1, 3'd1, 8'h81, 1'b0, 3'd0, 6'o01,
                     16'hEE81, 2'b00, 8'h04, 16'h0081, 2'b00, 8'h04};
        vecs[11] = '{1'b1, 1'b0, 3'd0, 8'h00, 1'b0, 3'd0, 8'h00, 1'b0, 3'd0, 6'o02,
                     16'h0000, 2'b00, 8'h00, 16'h0000, 2'b00, 8'h00};

        for (int i = 0; i < 12; i++) apply(vecs[i], i);

        // Forwarding: entry 4 holds 0x10 and is busy; wr1 writes 0x3C while port 1 reads it.
        @(negedge clk);
        wr0_en = 1'b1; wr0_addr = 3'd4; wr0_data = 8'h10;
        bsy_set_en = 1'b1; bsy_set_addr = 3'd4;
        @(posedge clk);
        #1;
        wr0_en = 1'b0; bsy_set_en = 1'b0;
        @(negedge clk);
        wr1_en = 1'b1; wr1_addr = 3'd4; wr1_data = 8'h3C;
        rd_addr = 6'o40;
        #1;
`ifdef REGFILE_MP_BYPASS_EN
        push("byp same-cycle rd_data", 0, 64'h3C00);
        push("byp same-cycle rd_busy", 1, 64'h0);
`else
        push("byp same-cycle rd_data", 0, 64'h1000);
        push("byp same-cycle rd_busy", 1, 64'h2);
`endif
        push("byp same-cycle busy_vec", 2, 64'h10);
        drain();
        @(posedge clk);
        #1;
        wr1_en = 1'b0;
        #1;
        push("byp next rd_data", 0, 64'h3C00);
        push("byp next rd_busy", 1, 64'h0);
        push("byp next busy_vec", 2, 64'h00);
        drain();

        // Wide four-port instance.
        @(negedge clk);
        q_rst = 1'b1;
        @(posedge clk);
        #1;
        q_rst = 1'b0;
        q_rd_addr = {3'd7, 3'd3, 3'd2, 3'd1};
        #1;
        push("wide reset rd_data", 6, 64'h0);
        push("wide reset busy_vec", 8, 64'h0);
        drain();
        @(negedge clk);
        q_wr0_en = 1'b1; q_wr0_addr = 3'd1; q_wr0_data = 16'h1234;
        q_wr1_en = 1'b1; q_wr1_addr = 3'd2; q_wr1_data = 16'hBEEF;
        @(negedge clk);
        q_wr0_addr = 3'd3; q_wr0_data = 16'h0001;
        q_wr1_addr = 3'd7; q_wr1_data = 16'hFFFF;
        q_bsy_set_en = 1'b1; q_bsy_set_addr = 3'd5;
        @(posedge clk);
        #1;
        q_wr0_en = 1'b0; q_wr1_en = 1'b0; q_bsy_set_en = 1'b0;
        #1;
        push("wide rd_data", 6, 64'hFFFF_0001_BEEF_1234);
        push("wide rd_busy", 7, 64'h0);
        push("wide busy_vec", 8, 64'h20);
        drain();
        @(negedge clk);
        q_bsy_set_en = 1'b1; q_bsy_set_addr = 3'd3;
        @(posedge clk);
        #1;
        q_bsy_set_en = 1'b0;
        #1;
        push("wide busy rd_busy", 7, 64'h4);
        push("wide busy busy_vec", 8, 64'h28);
        drain();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
